// File: rtl/fib_pkg.sv
// Shared constants, register map and FSM encoding for the Fibonacci engine
// Wishbone controller.
package fib_pkg;

    localparam int N_W   = 8;
    localparam int FN_W  = 32;
    localparam int CNT_W = 9;

    localparam logic [1:0] CTRL   = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;
    localparam logic [1:0] IRQ    = 2'd3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_IRQ_EN   = 2;
    localparam int STAT_IRQ_PEND = 3;

    localparam int CTRL_START_BIT = 8;
    localparam int IRQ_EN_BIT     = 0;
    localparam int IRQ_CLR_BIT    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fib_state_t;

    // Zero-extend n before adding the latency so n + lat never wraps.
    function automatic logic [CNT_W-1:0] cnt_load(input logic [N_W-1:0] n,
                                                  input logic [CNT_W-1:0] lat);
        return {1'b0, n} + lat;
    endfunction

endpackage

// File: rtl/fib_wb_ctrl.sv
// Wishbone slave that starts a Fibonacci engine and captures its result.
// Optional done interrupt enabled by defining FIB_WB_IRQ_EN.
module fib_wb_ctrl
    import fib_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          FIB_LAT   = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [3:0]      wbs_sel_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            fib_st,
    output logic [N_W-1:0]  fib_n,
    input  logic [FN_W-1:0] fib_fn
`ifdef FIB_WB_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(FIB_LAT);

    fib_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [FN_W-1:0]  result_r;

    logic             sel_s;
    logic             wr_s;
    logic [1:0]       off_s;
    logic             ctrl_wr_s;
    logic             start_req_s;
    logic [N_W-1:0]   n_next_s;
    logic             capture_s;
    logic             busy_s;
    logic             done_s;
    logic             irq_en_s;
    logic             irq_pend_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    // The ack term blocks re-selection, so a held strobe is acked every other cycle.
    assign sel_s       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
                         (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_s        = sel_s & wbs_we_i;
    assign off_s       = wbs_adr_i[3:2];
    assign ctrl_wr_s   = wr_s & (off_s == CTRL);
    assign start_req_s = ctrl_wr_s & wbs_sel_i[1] & wbs_dat_i[CTRL_START_BIT];
    assign n_next_s    = wbs_sel_i[0] ? wbs_dat_i[N_W-1:0] : fib_n;
    assign capture_s   = (state_r == WAIT) && (cnt_r == {CNT_W{1'b0}});
    assign busy_s      = (state_r == START) || (state_r == WAIT);
    assign done_s      = (state_r == DONE);
    assign unused_s    = ^{wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_sel_i[3:2]};

`ifdef FIB_WB_IRQ_EN
    logic irq_en_r;
    logic irq_pend_r;
    logic irq_wr_s;
    logic irq_en_nx_s;
    logic irq_pend_nx_s;

    assign irq_wr_s      = wr_s & (off_s == IRQ) & wbs_sel_i[0];
    assign irq_en_nx_s   = irq_wr_s ? wbs_dat_i[IRQ_EN_BIT] : irq_en_r;
    // A completion in the same cycle as a clear wins, so no done event is lost.
    assign irq_pend_nx_s = capture_s ? 1'b1 :
                           (irq_wr_s && wbs_dat_i[IRQ_CLR_BIT]) ? 1'b0 : irq_pend_r;
    assign irq_en_s      = irq_en_r;
    assign irq_pend_s    = irq_pend_r;

    // Interrupt enable, pending flag and registered interrupt line.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_r   <= 1'b0;
            irq_pend_r <= 1'b0;
            irq        <= 1'b0;
        end else begin
            irq_en_r   <= irq_en_nx_s;
            irq_pend_r <= irq_pend_nx_s;
            irq        <= irq_en_nx_s & irq_pend_nx_s;
        end
    end
`else
    assign irq_en_s   = 1'b0;
    assign irq_pend_s = 1'b0;
`endif

    // Read data mux; write-only bits and unmapped fields read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (off_s)
            CTRL:    rdata_s = 32'd0;
            STATUS:  rdata_s = {28'd0, irq_pend_s, irq_en_s, done_s, busy_s};
            RESULT:  rdata_s = result_r;
            IRQ:     rdata_s = {31'd0, irq_en_s};
            default: rdata_s = 32'd0;
        endcase
    end

    // Bus response: one-cycle ack with read data valid only alongside it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= sel_s;
            wbs_dat_o <= (sel_s && !wbs_we_i) ? rdata_s : 32'd0;
        end
    end

    // Engine sequencing FSM with index, latency counter and result capture.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r  <= IDLE;
            fib_st   <= 1'b0;
            fib_n    <= {N_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {FN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (ctrl_wr_s) begin
                        fib_n <= n_next_s;
                    end else begin
                        fib_n <= fib_n;
                    end
                    if (start_req_s) begin
                        state_r <= START;
                        fib_st  <= 1'b1;
                        cnt_r   <= cnt_load(n_next_s, LAT_C);
                    end else begin
                        state_r <= state_r;
                        fib_st  <= 1'b0;
                    end
                end
                START: begin
                    state_r <= WAIT;
                    fib_st  <= 1'b0;
                end
                WAIT: begin
                    fib_st <= 1'b0;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        result_r <= fib_fn;
                        state_r  <= DONE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    fib_st  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_wb_ctrl.sv
// Directed self-checking bench for fib_wb_ctrl: three instances with
// FIB_LAT = 2, 0 and 255 share one Wishbone bus at distinct base addresses.
module tb_fib_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_w = 32'd0;
    logic [3:0]  sel = 4'd0;

    logic        ack  [3];
    logic [31:0] rdat [3];
    logic        st   [3];
    logic [7:0]  nn   [3];
    logic [31:0] fn   [3];
    logic [31:0] e    [3];
    int          st_cnt [3];
    logic        fib_mode = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef FIB_WB_IRQ_EN
    logic        irq_o [3];
    logic        irq_q = 1'b0;
    logic [31:0] irq_e = 32'd0;
    logic        irq_at_ack = 1'b1;
`endif

    fib_wb_ctrl #(.BASE_ADDR(32'h3000_0000), .FIB_LAT(2)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
        .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]), .fib_st(st[0]), .fib_n(nn[0]),
        .fib_fn(fn[0])
`ifdef FIB_WB_IRQ_EN
        , .irq(irq_o[0])
`endif
    );

    fib_wb_ctrl #(.BASE_ADDR(32'h3000_0100), .FIB_LAT(0)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
        .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]), .fib_st(st[1]), .fib_n(nn[1]),
        .fib_fn(fn[1])
`ifdef FIB_WB_IRQ_EN
        , .irq(irq_o[1])
`endif
    );

    fib_wb_ctrl #(.BASE_ADDR(32'h3000_0200), .FIB_LAT(255)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_sel_i(sel),
        .wbs_ack_o(ack[2]), .wbs_dat_o(rdat[2]), .fib_st(st[2]), .fib_n(nn[2]),
        .fib_fn(fn[2])
`ifdef FIB_WB_IRQ_EN
        , .irq(irq_o[2])
`endif
    );

    function automatic logic [31:0] fib_calc(input logic [7:0] n);
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd1;
        logic [31:0] t;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Model engine: e counts cycles since the start pulse. In timing mode the
    // engine returns e itself, so the captured RESULT equals the WAIT cycles
    // spent before capture; in fib mode it returns fib(n) once n+2 cycles passed.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) e[i] <= 32'd0;
            else if (st[i]) e[i] <= 32'd0;
            else e[i] <= e[i] + 32'd1;
        end
    end

    always_comb begin
        fn[0] = fib_mode ? ((e[0] >= 32'(nn[0]) + 32'd2) ? fib_calc(nn[0]) : 32'd0) : e[0];
        fn[1] = e[1];
        fn[2] = e[2];
    end

    initial begin
        for (int i = 0; i < 3; i++) st_cnt[i] = 0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (st[i] === 1'b1) st_cnt[i] = st_cnt[i] + 1;
`ifdef FIB_WB_IRQ_EN
        if (irq_o[0] && !irq_q) irq_e = e[0];
        irq_q = irq_o[0];
        if (ack[0]) irq_at_ack = irq_o[0];
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base(input int idx);
        return 32'h3000_0000 + (32'(idx) << 8);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that follows the ack.
    task automatic wb_xfer(input int idx, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        lat = 0;
        r = 32'd0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (ack[idx] === 1'b1) begin
                lat = k;
                r = rdat[idx];
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int idx, input logic [3:0] off, input logic [31:0] d,
                      input logic [3:0] s);
        logic [31:0] r;
        int l;
        wb_xfer(idx, 1'b1, base(idx) + {28'd0, off}, d, s, r, l);
        check("wr_ack_lat", l, 1);
    endtask

    task automatic rd_chk(input int idx, input logic [3:0] off, input string tag,
                          input logic [31:0] exp);
        logic [31:0] r;
        int l;
        wb_xfer(idx, 1'b0, base(idx) + {28'd0, off}, 32'd0, 4'hF, r, l);
        check({tag, "_lat"}, l, 1);
        check(tag, r, exp);
        check({tag, "_dat_idle"}, rdat[idx], 32'd0);
    endtask

    task automatic wait_done(input int idx);
        logic [31:0] r;
        int l;
        r = 32'd0;
        for (int k = 0; k < 400; k++) begin
            wb_xfer(idx, 1'b0, base(idx) + 32'h4, 32'd0, 4'hF, r, l);
            if (r[1]) break;
        end
        check("done_seen", {31'd0, r[1]}, 32'd1);
    endtask

    initial begin
        int base_st;
        logic [31:0] r;
        int l;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack[0]}, 32'd0);
        check("rst_dat", rdat[0], 32'd0);
        check("rst_st", {31'd0, st[0]}, 32'd0);
        check("rst_n", {24'd0, nn[0]}, 32'd0);
`ifdef FIB_WB_IRQ_EN
        check("rst_irq", {31'd0, irq_o[0]}, 32'd0);
`endif
        rst = 1'b0;
        rd_chk(0, 4'h4, "status_after_rst", 32'd0);
        rd_chk(0, 4'h8, "result_after_rst", 32'd0);
        rd_chk(0, 4'h0, "ctrl_read_zero", 32'd0);

        // Stored n without start, byte-enable qualification
        base_st = st_cnt[0];
        wr(0, 4'h0, 32'h0000_0007, 4'hF);
        check("n_set_7", {24'd0, nn[0]}, 32'd7);
        wr(0, 4'h0, 32'h0000_01FF, 4'h1);
        check("n_set_ff_nostart", {24'd0, nn[0]}, 32'hFF);
        rd_chk(0, 4'h4, "status_idle", 32'd0);
        check("no_start_pulse", st_cnt[0] - base_st, 0);
        wr(0, 4'h0, 32'h0000_0003, 4'h1);
        fib_mode = 1'b0;
        wr(0, 4'h0, 32'h0000_01AA, 4'h2);
        check("start_keeps_n", {24'd0, nn[0]}, 32'd3);
        wait_done(0);
        rd_chk(0, 4'h8, "result_n3_timing", 32'd5);
        check("st_pulse_n3", st_cnt[0] - base_st, 1);

        // n = 10 timing run with an ignored CTRL write during WAIT
        base_st = st_cnt[0];
        wr(0, 4'h0, 32'h0000_010A, 4'hF);
        rd_chk(0, 4'h4, "status_busy", 32'd1);
        wr(0, 4'h0, 32'h0000_0114, 4'hF);
        check("n_kept_in_wait", {24'd0, nn[0]}, 32'd10);
        wait_done(0);
        rd_chk(0, 4'h8, "result_n10_wait_cycles", 32'd12);
        check("st_pulse_n10", st_cnt[0] - base_st, 1);

        // n = 10 with the Fibonacci model engine
        fib_mode = 1'b1;
        base_st = st_cnt[0];
        wr(0, 4'h0, 32'h0000_010A, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        wr(0, 4'h0, 32'h0000_0114, 4'hF);
        wait_done(0);
        rd_chk(0, 4'h8, "result_fib10", 32'd55);
        check("st_pulse_fib10", st_cnt[0] - base_st, 1);
        check("n_after_fib10", {24'd0, nn[0]}, 32'd10);
        rd_chk(0, 4'h4, "status_done", 32'd2);

        // Writes to read-only registers are acked and ignored
        wr(0, 4'h4, 32'hFFFF_FFFF, 4'hF);
        wr(0, 4'h8, 32'h0000_0000, 4'hF);
        rd_chk(0, 4'h4, "status_ro", 32'd2);
        rd_chk(0, 4'h8, "result_ro", 32'd55);

        // Held strobe: ack is a single-cycle pulse
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0008; sel = 4'hF;
        @(posedge clk);
        #1;
        check("held_ack_hi", {31'd0, ack[0]}, 32'd1);
        check("held_dat", rdat[0], 32'd55);
        @(posedge clk);
        #1;
        check("held_ack_lo", {31'd0, ack[0]}, 32'd0);
        check("held_dat_lo", rdat[0], 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;

        // Out-of-window address is never acked
        wb_xfer(0, 1'b0, 32'h3000_0010, 32'd0, 4'hF, r, l);
        check("no_ack_0x10", l, 0);

`ifndef FIB_WB_IRQ_EN
        rd_chk(0, 4'hC, "irq_off_read", 32'd0);
        wr(0, 4'hC, 32'h0000_0003, 4'hF);
        rd_chk(0, 4'hC, "irq_off_after_wr", 32'd0);
        rd_chk(0, 4'h4, "status_no_irq_bits", 32'd2);
`endif

        // Counter boundaries: n=0/LAT=0 and n=255/LAT=255
        wr(1, 4'h0, 32'h0000_0100, 4'hF);
        wait_done(1);
        rd_chk(1, 4'h8, "result_n0_lat0", 32'd0);
        wr(1, 4'h0, 32'h0000_0105, 4'hF);
        wait_done(1);
        rd_chk(1, 4'h8, "result_n5_lat0", 32'd5);
        wr(2, 4'h0, 32'h0000_01FF, 4'hF);
        wait_done(2);
        rd_chk(2, 4'h8, "result_n255_lat255", 32'd510);

`ifdef FIB_WB_IRQ_EN
        fib_mode = 1'b0;
        wr(0, 4'hC, 32'h0000_0001, 4'hF);
        rd_chk(0, 4'hC, "irq_en_read", 32'd1);
        wr(0, 4'h0, 32'h0000_0105, 4'hF);
        wait_done(0);
        check("irq_rise_cycle", irq_e, 32'd8);
        check("irq_high", {31'd0, irq_o[0]}, 32'd1);
        rd_chk(0, 4'h4, "status_irq", 32'hE);
        wr(0, 4'hC, 32'h0000_0003, 4'hF);
        check("irq_drop_at_ack", {31'd0, irq_at_ack}, 32'd0);
        rd_chk(0, 4'h4, "status_irq_clr", 32'h6);
`endif

        // Reset in the middle of WAIT
        fib_mode = 1'b0;
        base_st = st_cnt[0];
        wr(0, 4'h0, 32'h0000_0164, 4'hF);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_st", {31'd0, st[0]}, 32'd0);
        check("midrst_n", {24'd0, nn[0]}, 32'd0);
        check("midrst_ack", {31'd0, ack[0]}, 32'd0);
`ifdef FIB_WB_IRQ_EN
        check("midrst_irq", {31'd0, irq_o[0]}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_chk(0, 4'h4, "midrst_status", 32'd0);
        rd_chk(0, 4'h8, "midrst_result", 32'd0);
        repeat (200) @(posedge clk);
        #1;
        rd_chk(0, 4'h4, "midrst_status_late", 32'd0);
        rd_chk(0, 4'h8, "midrst_no_capture", 32'd0);
        check("midrst_one_pulse", st_cnt[0] - base_st, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_wb_ctrl.md
FIB_WB_CTRL -- requirements
Module: fib_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, the Wishbone base address; bits [31:4] are matched.
REQ-002 SHALL have parameter FIB_LAT, default 2, the extra cycles beyond n that the engine needs before fib_fn is valid (range 0..255).
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock for all state, rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each input, 1 bit: Wishbone classic cycle, strobe and write.
REQ-006 SHALL have ports wbs_adr_i (input, 32 bits), wbs_dat_i (input, 32 bits) and wbs_sel_i (input, 4 bits): address, write data and byte enables.
REQ-007 SHALL have ports wbs_ack_o (output, 1 bit) and wbs_dat_o (output, 32 bits): acknowledge and read data.
REQ-008 SHALL have ports fib_st (output, 1 bit), fib_n (output, 8 bits) and fib_fn (input, 32 bits): the downstream engine's start, index and result.
REQ-009 SHALL have port irq, output, 1 bit: done interrupt, present only under FIB_WB_IRQ_EN.

Function
REQ-010 Access SHALL be selected when wbs_cyc_i & wbs_stb_i are high, wbs_ack_o is low and wbs_adr_i[31:4] == BASE_ADDR[31:4].
REQ-011 A selected access SHALL be acked one cycle after selection, as a one-cycle pulse.
- Back-to-back accesses are therefore spaced by at least 2 cycles.
- Non-matching addresses are never acked.
REQ-012 Registers SHALL be decoded on wbs_adr_i[3:2].
- 0 = CTRL (W): bits [7:0] = n, qualified by sel[0]; bit 8 = start, qualified by sel[1].
- 1 = STATUS (R): bit0 busy, bit1 done, bit2 irq_en, bit3 irq_pend.
- 2 = RESULT (R): captured fib_fn.
- 3 = IRQ (R/W): bit0 irq_en; writing bit1 = 1 clears irq_pend.
REQ-013 Reads of unmapped offsets, and of write-only bits, SHALL return 0; writes to read-only registers SHALL be acked and ignored.
REQ-014 wbs_dat_o SHALL be registered, valid in the ack cycle, and 0 in all other cycles.
REQ-015 The FSM SHALL have states IDLE, START, WAIT and DONE, with these transitions:
- IDLE or DONE -> START on a CTRL write with start = 1: latches n into fib_n, loads a 9-bit counter with n + FIB_LAT, clears done.
- START -> WAIT after exactly one cycle; fib_st is high only in START.
- WAIT: the counter decrements every cycle; when it equals 0, RESULT <= fib_fn and the FSM goes to DONE.
REQ-016 A CTRL write received in START or WAIT SHALL be acked and fully ignored; fib_n, the counter and RESULT are unchanged.
REQ-017 busy SHALL be 1 in START and WAIT, and 0 otherwise.
- done SHALL be 1 in DONE only.
- RESULT holds its value until the next capture.
REQ-018 When n = 0 and FIB_LAT = 0, capture SHALL occur in the first WAIT cycle.
- Maximum n + FIB_LAT = 510 SHALL fit the 9-bit counter without wrap.
REQ-019 A CTRL write with start = 0 SHALL update the stored n only in IDLE or DONE, and SHALL NOT start the engine.
REQ-020 When a start write occurs in the same cycle as capture, the write SHALL be ignored (the FSM is in WAIT).

Reset
REQ-021 Asserting wb_rst_i SHALL immediately set all of the following, including mid-operation:
- FSM = IDLE.
- wbs_ack_o = 0 and wbs_dat_o = 0.
- fib_st = 0 and fib_n = 0.
- RESULT = 0 and counter = 0.
- irq_en = 0, irq_pend = 0 and irq = 0.
REQ-022 After wb_rst_i deasserts, the first access SHALL be accepted in the next cycle.

Configuration
REQ-023 With FIB_WB_IRQ_EN defined:
- irq_pend sets on the WAIT->DONE transition.
- irq = irq_pend & irq_en.
REQ-024 Without FIB_WB_IRQ_EN:
- The irq port, irq_en and irq_pend are absent.
- The IRQ offset and STATUS bits [3:2] read 0.
- Writes to the IRQ offset are acked and ignored.

Structure
REQ-025 Package fib_pkg SHALL hold:
- Register offset constants CTRL, STATUS, RESULT and IRQ.
- STATUS bit index constants.
- The FSM state enum.
- The width constants N_W = 8, FN_W = 32 and CNT_W = 9.
REQ-026 Decode, FSM and counter SHALL live in fib_wb_ctrl; no sub-module is required.

Verification
REQ-027 A write of CTRL = 0x10A (start, n = 10) with FIB_LAT = 2 and a model engine SHALL produce:
- fib_st high for exactly 1 cycle.
- done after 12 WAIT cycles.
- A RESULT read returning 55.
REQ-028 A CTRL write of 0x114 issued during WAIT of the 0x10A run SHALL be acked, and RESULT SHALL still read 55.
REQ-029 A start with n = 0 and FIB_LAT = 0 SHALL capture 1 cycle after START; a start with n = 255 and FIB_LAT = 255 SHALL capture after 510 cycles.
REQ-030 wb_rst_i pulsed during WAIT SHALL produce:
- FSM = IDLE, with STATUS reading 0 and RESULT reading 0.
- fib_st = 0.
- No capture afterwards.
REQ-031 A read at BASE_ADDR + 0xC with the macro off SHALL return 0; a read at 0x3000_0010 SHALL receive no ack.
REQ-032 With FIB_WB_IRQ_EN defined, irq_en = 1 and start with n = 5:
- irq rises on the DONE cycle.
- A write of IRQ = 0x3 drops irq the next cycle.
